// File: rtl/mm_pkg.sv
// Shared definitions for the dot-product stage: feeder FSM states, latencies and default widths.
package mm_pkg;

    localparam int unsigned DEFAULT_DATA_WIDTH = 32;
    localparam int unsigned DEFAULT_ADDR_WIDTH = 8;
    localparam int unsigned DEFAULT_K_WIDTH    = 8;

    localparam int unsigned MEM_RD_LATENCY = 1;
    localparam int unsigned PE_LATENCY     = 3;
    localparam int unsigned DRAIN_CYCLES   = MEM_RD_LATENCY + PE_LATENCY;

    typedef logic [2:0] state_t;

    localparam state_t StIdle  = 3'd0;
    localparam state_t StStart = 3'd1;
    localparam state_t StIssue = 3'd2;
    localparam state_t StDrain = 3'd3;
    localparam state_t StDone  = 3'd4;

endpackage

// File: rtl/operand_addr_gen.sv
// Element index and strided B pointer for one dot-product command; all address arithmetic wraps.
module operand_addr_gen
    import mm_pkg::*;
#(
    parameter int unsigned ADDR_WIDTH = DEFAULT_ADDR_WIDTH,
    parameter int unsigned K_WIDTH    = DEFAULT_K_WIDTH
) (
    input  logic                  clk,
    input  logic                  clr,
    input  logic                  load,
    input  logic                  step,
    input  logic [ADDR_WIDTH-1:0] a_base,
    input  logic [ADDR_WIDTH-1:0] b_base,
    input  logic [ADDR_WIDTH-1:0] b_stride,
    input  logic [K_WIDTH-1:0]    k,
    output logic [ADDR_WIDTH-1:0] a_addr,
    output logic [ADDR_WIDTH-1:0] b_addr,
    output logic                  is_last
);

    logic [K_WIDTH-1:0]    i_q, i_d;
    logic [ADDR_WIDTH-1:0] b_ptr_q, b_ptr_d;

    always_comb begin
        i_d     = i_q;
        b_ptr_d = b_ptr_q;
        if (load) begin
            i_d     = '0;
            b_ptr_d = b_base;
        end else if (step) begin
            i_d     = i_q + K_WIDTH'(1);
            b_ptr_d = b_ptr_q + b_stride;
        end
    end

    always_ff @(posedge clk) begin
        if (clr) begin
            i_q     <= '0;
            b_ptr_q <= '0;
        end else begin
            i_q     <= i_d;
            b_ptr_q <= b_ptr_d;
        end
    end

    assign a_addr  = a_base + ADDR_WIDTH'(i_q);
    assign b_addr  = b_ptr_q;
    assign is_last = (i_q == k - K_WIDTH'(1));

endmodule

// File: rtl/pe_operand_feeder.sv
// Sequences one dot-product command into the PE: clear, K operand pairs from the buffers, then a
// drain so the next clear can never land on an accumulation still in flight.
module pe_operand_feeder
    import mm_pkg::*;
#(
    parameter int unsigned DATA_WIDTH = DEFAULT_DATA_WIDTH,
    parameter int unsigned ADDR_WIDTH = DEFAULT_ADDR_WIDTH,
    parameter int unsigned K_WIDTH    = DEFAULT_K_WIDTH
) (
    input  logic                  clk,
    input  logic                  clr,
    input  logic                  cmd_valid,
    output logic                  cmd_ready,
    input  logic [ADDR_WIDTH-1:0] cmd_a_base,
    input  logic [ADDR_WIDTH-1:0] cmd_b_base,
    input  logic [ADDR_WIDTH-1:0] cmd_b_stride,
    input  logic [K_WIDTH-1:0]    cmd_k,
    input  logic                  hold,
    output logic                  a_rd_en,
    output logic                  b_rd_en,
    output logic [ADDR_WIDTH-1:0] a_rd_addr,
    output logic [ADDR_WIDTH-1:0] b_rd_addr,
    input  logic [DATA_WIDTH-1:0] a_rd_data,
    input  logic [DATA_WIDTH-1:0] b_rd_data,
    output logic                  pe_start,
    output logic                  pe_valid_in,
    output logic                  pe_last,
    output logic [DATA_WIDTH-1:0] pe_a,
    output logic [DATA_WIDTH-1:0] pe_b,
    output logic                  done
);

    localparam int unsigned       DrainW    = $clog2(DRAIN_CYCLES + 1);
    localparam logic [DrainW-1:0] DrainLast = DrainW'(DRAIN_CYCLES - 1);

    state_t                  state_q, state_d;
    logic [ADDR_WIDTH-1:0]   a_base_q, a_base_d;
    logic [ADDR_WIDTH-1:0]   b_stride_q, b_stride_d;
    logic [K_WIDTH-1:0]      k_q, k_d;
    logic [DrainW-1:0]       drain_cnt_q, drain_cnt_d;
    logic                    vld_q, vld_d;
    logic                    last_q, last_d;

    logic                    cmd_accept;
    logic                    issue;
    logic                    is_last;
    logic [ADDR_WIDTH-1:0]   a_addr, b_addr;

    // Every output is forced low while clr is high, whatever the current state.
    assign cmd_ready   = !clr && (state_q == StIdle);
    assign pe_start    = !clr && (state_q == StStart);
    assign done        = !clr && (state_q == StDone);
    assign issue       = !clr && (state_q == StIssue) && !hold;
    assign cmd_accept  = cmd_valid && cmd_ready;

    assign a_rd_en     = issue;
    assign b_rd_en     = issue;
    assign a_rd_addr   = issue ? a_addr : '0;
    assign b_rd_addr   = issue ? b_addr : '0;

    assign pe_valid_in = !clr && vld_q;
    assign pe_last     = !clr && last_q;
    assign pe_a        = pe_valid_in ? a_rd_data : '0;
    assign pe_b        = pe_valid_in ? b_rd_data : '0;

    operand_addr_gen #(
        .ADDR_WIDTH (ADDR_WIDTH),
        .K_WIDTH    (K_WIDTH)
    ) u_addr_gen (
        .clk      (clk),
        .clr      (clr),
        .load     (cmd_accept),
        .step     (issue),
        .a_base   (a_base_q),
        .b_base   (cmd_b_base),
        .b_stride (b_stride_q),
        .k        (k_q),
        .a_addr   (a_addr),
        .b_addr   (b_addr),
        .is_last  (is_last)
    );

    always_comb begin
        state_d     = state_q;
        a_base_d    = a_base_q;
        b_stride_d  = b_stride_q;
        k_d         = k_q;
        drain_cnt_d = drain_cnt_q;
        unique case (state_q)
            StIdle: begin
                if (cmd_accept) begin
                    a_base_d   = cmd_a_base;
                    b_stride_d = cmd_b_stride;
                    k_d        = cmd_k;
                    state_d    = (cmd_k != '0) ? StStart : StDone;
                end
            end
            StStart: state_d = StIssue;
            StIssue: begin
                if (issue && is_last) begin
                    state_d     = StDrain;
                    drain_cnt_d = '0;
                end
            end
            StDrain: begin
                if (drain_cnt_q == DrainLast) begin
                    state_d = StDone;
                end else begin
                    drain_cnt_d = drain_cnt_q + DrainW'(1);
                end
            end
            StDone:  state_d = StIdle;
            default: state_d = StIdle;
        endcase
    end

    // Return flags travel one cycle behind the strobe, matching the buffer read latency.
    assign vld_d  = issue;
    assign last_d = issue && is_last;

    always_ff @(posedge clk) begin
        if (clr) begin
            state_q     <= StIdle;
            a_base_q    <= '0;
            b_stride_q  <= '0;
            k_q         <= '0;
            drain_cnt_q <= '0;
            vld_q       <= 1'b0;
            last_q      <= 1'b0;
        end else begin
            state_q     <= state_d;
            a_base_q    <= a_base_d;
            b_stride_q  <= b_stride_d;
            k_q         <= k_d;
            drain_cnt_q <= drain_cnt_d;
            vld_q       <= vld_d;
            last_q      <= last_d;
        end
    end

endmodule

// File: tb/tb_pe_operand_feeder.sv
// Cycle-accurate bench: per command, an expected trace is built from the timing rules and compared.
module tb_pe_operand_feeder;

    localparam int MAXC = 1024;

    logic        clk = 1'b0;
    logic        clr, cmd_valid, cmd_ready, hold;
    logic [7:0]  cmd_a_base, cmd_b_base, cmd_b_stride, cmd_k;
    logic        a_rd_en, b_rd_en;
    logic [7:0]  a_rd_addr, b_rd_addr;
    logic [31:0] a_rd_data, b_rd_data;
    logic        pe_start, pe_valid_in, pe_last, done;
    logic [31:0] pe_a, pe_b;

    logic [31:0] a_mem [256];
    logic [31:0] b_mem [256];

    logic        e_start [MAXC];
    logic        e_rd    [MAXC];
    logic [7:0]  e_aa    [MAXC];
    logic [7:0]  e_ba    [MAXC];
    logic        e_vld   [MAXC];
    logic        e_last  [MAXC];
    logic [31:0] e_a     [MAXC];
    logic [31:0] e_b     [MAXC];
    logic        e_done  [MAXC];
    logic        e_ready [MAXC];
    logic        hold_pat[MAXC];

    int n_vec = 0;
    int n_err = 0;
    int cur_c = 0;

    always #5 clk = ~clk;

    pe_operand_feeder dut (
        .clk          (clk),
        .clr          (clr),
        .cmd_valid    (cmd_valid),
        .cmd_ready    (cmd_ready),
        .cmd_a_base   (cmd_a_base),
        .cmd_b_base   (cmd_b_base),
        .cmd_b_stride (cmd_b_stride),
        .cmd_k        (cmd_k),
        .hold         (hold),
        .a_rd_en      (a_rd_en),
        .b_rd_en      (b_rd_en),
        .a_rd_addr    (a_rd_addr),
        .b_rd_addr    (b_rd_addr),
        .a_rd_data    (a_rd_data),
        .b_rd_data    (b_rd_data),
        .pe_start     (pe_start),
        .pe_valid_in  (pe_valid_in),
        .pe_last      (pe_last),
        .pe_a         (pe_a),
        .pe_b         (pe_b),
        .done         (done)
    );

    // Synchronous-read operand buffers.
    always @(posedge clk) begin
        if (a_rd_en) a_rd_data <= a_mem[a_rd_addr];
        if (b_rd_en) b_rd_data <= b_mem[b_rd_addr];
    end

    task automatic chk(input string tag, input logic [31:0] obs, input logic [31:0] exp);
        n_vec++;
        assert (obs === exp) else begin
            n_err++;
            $error("FAIL %s cycle %0d: observed %h expected %h", tag, cur_c, obs, exp);
        end
    endtask

    task automatic chk_all(input int c, input bit addr_chk);
        cur_c = c;
        chk("cmd_ready",   32'(cmd_ready),   32'(e_ready[c]));
        chk("pe_start",    32'(pe_start),    32'(e_start[c]));
        chk("a_rd_en",     32'(a_rd_en),     32'(e_rd[c]));
        chk("b_rd_en",     32'(b_rd_en),     32'(e_rd[c]));
        if (addr_chk) begin
            chk("a_rd_addr", 32'(a_rd_addr), 32'(e_aa[c]));
            chk("b_rd_addr", 32'(b_rd_addr), 32'(e_ba[c]));
        end
        chk("pe_valid_in", 32'(pe_valid_in), 32'(e_vld[c]));
        chk("pe_last",     32'(pe_last),     32'(e_last[c]));
        chk("pe_a",        pe_a,             e_a[c]);
        chk("pe_b",        pe_b,             e_b[c]);
        chk("done",        32'(done),        32'(e_done[c]));
    endtask

    // Entered mid-cycle with the DUT idle; that cycle is cycle 0 (the accept cycle).
    // Returns mid-cycle in the first cycle where cmd_ready is high again.
    task automatic run_cmd(input logic [7:0] ab, input logic [7:0] bb, input logic [7:0] st,
                           input logic [7:0] k, input int hold_pct, input int hold_at,
                           input bit keep_valid, input int clr_at);
        int c, j, end_c;
        for (int i = 0; i < MAXC; i++) begin
            e_start[i] = 0; e_rd[i] = 0; e_aa[i] = 0; e_ba[i] = 0; e_vld[i] = 0;
            e_last[i] = 0; e_a[i] = 0; e_b[i] = 0; e_done[i] = 0; e_ready[i] = 0;
            hold_pat[i] = ($urandom_range(99) < hold_pct);
        end
        if (hold_at > 0) hold_pat[hold_at] = 1'b1;
        if (k == 8'd0) begin
            e_done[1] = 1'b1;
            end_c = 2;
        end else begin
            e_start[1] = 1'b1;
            j = 0;
            c = 2;
            while (j < int'(k) && c < MAXC - 8) begin
                if (!hold_pat[c]) begin
                    e_rd[c]       = 1'b1;
                    e_aa[c]       = 8'(int'(ab) + j);
                    e_ba[c]       = 8'(int'(bb) + int'(st) * j);
                    e_vld[c+1]    = 1'b1;
                    e_a[c+1]      = a_mem[e_aa[c]];
                    e_b[c+1]      = b_mem[e_ba[c]];
                    e_last[c+1]   = (j == int'(k) - 1);
                    j++;
                end
                c++;
            end
            // c-1 is the final strobe: read return plus PE latency, then done.
            e_done[c + 4] = 1'b1;
            end_c = c + 5;
        end
        e_ready[0]     = 1'b1;
        e_ready[end_c] = 1'b1;
        if (clr_at > 0) begin
            for (int i = clr_at; i < MAXC; i++) begin
                e_start[i] = 0; e_rd[i] = 0; e_aa[i] = 0; e_ba[i] = 0; e_vld[i] = 0;
                e_last[i] = 0; e_a[i] = 0; e_b[i] = 0; e_done[i] = 0;
                e_ready[i] = (i > clr_at);
            end
            end_c = clr_at + 3;
        end

        cmd_valid    = 1'b1;
        cmd_a_base   = ab;
        cmd_b_base   = bb;
        cmd_b_stride = st;
        cmd_k        = k;
        hold         = hold_pat[0];
        chk("accept_ready", 32'(cmd_ready), 32'(e_ready[0]));
        for (int cc = 1; cc <= end_c; cc++) begin
            @(posedge clk);
            #1;
            cmd_valid    = keep_valid;
            cmd_a_base   = 8'($urandom);
            cmd_b_base   = 8'($urandom);
            cmd_b_stride = 8'($urandom);
            cmd_k        = 8'($urandom);
            hold         = hold_pat[cc];
            clr          = (cc == clr_at);
            @(negedge clk);
            chk_all(cc, e_rd[cc] || (cc == clr_at));
        end
        clr = 1'b0;
    endtask

    initial begin
        for (int i = 0; i < 256; i++) begin
            a_mem[i] = $urandom;
            b_mem[i] = $urandom;
        end
        a_rd_data    = '0;
        b_rd_data    = '0;
        clr          = 1'b1;
        cmd_valid    = 1'b0;
        hold         = 1'b0;
        cmd_a_base   = '0;
        cmd_b_base   = '0;
        cmd_b_stride = '0;
        cmd_k        = '0;

        // Reset: every output low while clr is held.
        for (int i = 0; i < MAXC; i++) begin
            e_start[i] = 0; e_rd[i] = 0; e_aa[i] = 0; e_ba[i] = 0; e_vld[i] = 0;
            e_last[i] = 0; e_a[i] = 0; e_b[i] = 0; e_done[i] = 0; e_ready[i] = 0;
        end
        for (int r = 0; r < 2; r++) begin
            @(negedge clk);
            chk_all(0, 1'b1);
        end
        @(posedge clk);
        #1;
        clr = 1'b0;
        @(negedge clk);
        cur_c = 0;
        chk("ready_after_clr", 32'(cmd_ready), 32'd1);

        // Directed cases.
        run_cmd(8'h10, 8'h20, 8'd1, 8'd4, 0, 0, 1'b0, 0);   // basic K=4
        run_cmd(8'hFE, 8'hF8, 8'd4, 8'd4, 0, 0, 1'b0, 0);   // address wrap and stride
        run_cmd(8'h00, 8'h40, 8'd2, 8'd3, 0, 3, 1'b0, 0);   // hold in 2nd ISSUE cycle
        run_cmd(8'h33, 8'h44, 8'd1, 8'd0, 0, 0, 1'b0, 0);   // K=0
        run_cmd(8'h50, 8'h60, 8'd3, 8'd1, 0, 0, 1'b0, 0);   // K=1
        run_cmd(8'h70, 8'h80, 8'd1, 8'd2, 0, 0, 1'b1, 0);   // back-to-back, valid held
        run_cmd(8'h90, 8'hA0, 8'd5, 8'd2, 0, 0, 1'b0, 0);
        run_cmd(8'h08, 8'h18, 8'd1, 8'd8, 0, 0, 1'b0, 5);   // clr during ISSUE

        // Randomised commands with random hold.
        for (int n = 0; n < 12; n++) begin
            run_cmd(8'($urandom), 8'($urandom), 8'($urandom), 8'($urandom_range(12)),
                    25, 0, 1'($urandom), 0);
        end
        run_cmd(8'($urandom), 8'($urandom), 8'($urandom), 8'd255, 10, 0, 1'b0, 0);

        $display("== %0d vectors applied, %0d miscompares ==", n_vec, n_err);
        $finish;
    end

endmodule
